// File: rtl/ccip_c1_tx_buffer.sv
// ccip_c1_tx_buffer: C1 write-request FIFO between the NLB AFU Tx port and the async shim Tx port.
// Latency: 2 edges minimum (push edge, then pop edge registers the head onto out_*); 1 req/clk sustained.
// Backpressure: out_almfull stalls the drain; in_almfull is raised with AF_SLACK free entries left.
//
// Ports:
//   afu_clk, afu_softreset   clock, asynchronous active-high reset
//   in_valid/in_hdr/in_data  request from the AFU (valid-only, no ready)
//   in_almfull               registered almost-full toward the AFU
//   out_valid/out_hdr/out_data  request toward the shim, one-cycle pulse per request
//   out_almfull              shim almost-full; while high nothing is issued
//   occupancy, overflow      entry count; sticky flag for a push dropped into a full FIFO
// Optional: define CCIP_C1_TX_BUFFER_STATS_EN to add stat_in_cnt, stat_out_cnt,
//   stat_max_occ and stat_stall_cyc.
module ccip_c1_tx_buffer #(
  parameter int HDR_W    = 80,
  parameter int DATA_W   = 512,
  parameter int DEPTH    = 64,
  parameter int AF_SLACK = 8
) (
  input  logic                     afu_clk,
  input  logic                     afu_softreset,
  input  logic                     in_valid,
  input  logic [HDR_W-1:0]         in_hdr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_almfull,
  output logic                     out_valid,
  output logic [HDR_W-1:0]         out_hdr,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_almfull,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
`ifdef CCIP_C1_TX_BUFFER_STATS_EN
  ,
  output logic [31:0]              stat_in_cnt,
  output logic [31:0]              stat_out_cnt,
  output logic [$clog2(DEPTH):0]   stat_max_occ,
  output logic [31:0]              stat_stall_cyc
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = HDR_W + DATA_W;
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_AF   = (AW+1)'(DEPTH - AF_SLACK);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ_next;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Full is judged on the registered count, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  always_comb begin
    empty    = (occupancy == '0);
    full     = (occupancy == OCC_FULL);
    push     = in_valid && !full;
    pop      = !empty && !out_almfull;
    occ_next = occupancy;
    if (push && !pop)
      occ_next = occupancy + OCC_ONE;
    else if (pop && !push)
      occ_next = occupancy - OCC_ONE;
  end

  // Storage has no reset so it maps onto block RAM; emptiness is tracked
  // entirely by the pointers and occupancy.
  always_ff @(posedge afu_clk) begin
    if (push)
      mem[wr_ptr] <= {in_hdr, in_data};
  end

  // Write and read never hit the same address in one cycle: a read needs a
  // non-empty FIFO and a write needs a non-full one, so rd_ptr != wr_ptr.
  always_ff @(posedge afu_clk or posedge afu_softreset) begin
    if (afu_softreset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      in_almfull <= 1'b0;
      out_valid  <= 1'b0;
      out_hdr    <= '0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr              <= rd_ptr + PTR_ONE;
        {out_hdr, out_data} <= mem[rd_ptr];
      end
      out_valid  <= pop;
      occupancy  <= occ_next;
      in_almfull <= (occ_next >= OCC_AF);
      if (in_valid && full)
        overflow <= 1'b1;
    end
  end

`ifdef CCIP_C1_TX_BUFFER_STATS_EN
  always_ff @(posedge afu_clk or posedge afu_softreset) begin
    if (afu_softreset) begin
      stat_in_cnt    <= '0;
      stat_out_cnt   <= '0;
      stat_max_occ   <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (push)
        stat_in_cnt <= stat_in_cnt + 32'd1;
      if (pop)
        stat_out_cnt <= stat_out_cnt + 32'd1;
      if (occ_next > stat_max_occ)
        stat_max_occ <= occ_next;
      if (!empty && out_almfull)
        stat_stall_cyc <= stat_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccip_c1_tx_buffer.sv
// Directed bench for ccip_c1_tx_buffer (default parameters: 80/512/64/8).
// Output order is tracked with a queue of expected request tags.
module tb_ccip_c1_tx_buffer;

  logic         afu_clk = 1'b0;
  logic         afu_softreset;
  logic         in_valid;
  logic [79:0]  in_hdr;
  logic [511:0] in_data;
  logic         in_almfull;
  logic         out_valid;
  logic [79:0]  out_hdr;
  logic [511:0] out_data;
  logic         out_almfull;
  logic [6:0]   occupancy;
  logic         overflow;
`ifdef CCIP_C1_TX_BUFFER_STATS_EN
  logic [31:0]  stat_in_cnt;
  logic [31:0]  stat_out_cnt;
  logic [6:0]   stat_max_occ;
  logic [31:0]  stat_stall_cyc;
`endif

  ccip_c1_tx_buffer dut (
    .afu_clk       (afu_clk),
    .afu_softreset (afu_softreset),
    .in_valid      (in_valid),
    .in_hdr        (in_hdr),
    .in_data       (in_data),
    .in_almfull    (in_almfull),
    .out_valid     (out_valid),
    .out_hdr       (out_hdr),
    .out_data      (out_data),
    .out_almfull   (out_almfull),
    .occupancy     (occupancy),
    .overflow      (overflow)
`ifdef CCIP_C1_TX_BUFFER_STATS_EN
    ,
    .stat_in_cnt   (stat_in_cnt),
    .stat_out_cnt  (stat_out_cnt),
    .stat_max_occ  (stat_max_occ),
    .stat_stall_cyc(stat_stall_cyc)
`endif
  );

  always #5 afu_clk = ~afu_clk;

  int n_eval = 0;
  int n_fail = 0;
  int cyc = 0;
  int out_cnt = 0;
  int first_out = -1;
  int tag_n = 0;
  int c0;
  int base;
  int exp_q[$];

  function automatic logic [79:0] mk_hdr(int tag);
    return {16'hC1A5, tag[31:0], ~tag[31:0]};
  endfunction

  function automatic logic [511:0] mk_data(int tag);
    return {16{tag[31:0] ^ 32'h5A5A_0000}};
  endfunction

  task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
    n_eval++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and score any issued request.
  task automatic step();
    int t;
    @(posedge afu_clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      out_cnt++;
      if (first_out < 0) first_out = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 512'(out_hdr), 512'd0);
      end else begin
        t = exp_q.pop_front();
        check("out_hdr_order", 512'(out_hdr), 512'(mk_hdr(t)));
        check("out_data_order", out_data, mk_data(t));
      end
    end
  endtask

  task automatic push(bit accepted);
    in_valid = 1'b1;
    in_hdr   = mk_hdr(tag_n);
    in_data  = mk_data(tag_n);
    if (accepted) exp_q.push_back(tag_n);
    tag_n++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(string pfx);
    check({pfx, "_in_almfull"}, 512'(in_almfull), 512'd0);
    check({pfx, "_out_valid"},  512'(out_valid),  512'd0);
    check({pfx, "_out_hdr"},    512'(out_hdr),    512'd0);
    check({pfx, "_out_data"},   out_data,         512'd0);
    check({pfx, "_occupancy"},  512'(occupancy),  512'd0);
    check({pfx, "_overflow"},   512'(overflow),   512'd0);
  endtask

  initial begin
    afu_softreset = 1'b1;
    in_valid      = 1'b0;
    in_hdr        = '0;
    in_data       = '0;
    out_almfull   = 1'b0;
    repeat (3) step();
    check_reset_vals("rst");
    afu_softreset = 1'b0;
    step();

    // 20 back-to-back pushes, shim open: in order, first issue one edge after the push edge.
    c0 = cyc + 1;
    first_out = -1;
    base = out_cnt;
    for (int i = 0; i < 20; i++) push(1'b1);
    repeat (10) step();
    check("t1_out_count", 512'(out_cnt - base), 512'd20);
    check("t1_first_latency", 512'(first_out), 512'(c0 + 1));
    check("t1_occupancy", 512'(occupancy), 512'd0);
    check("t1_in_almfull", 512'(in_almfull), 512'd0);

    // Shim stalled: 56 pushes raise in_almfull exactly when occupancy reaches 56.
    out_almfull = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 56; i++) begin
      push(1'b1);
      if (i == 54) begin
        check("t2_occ55", 512'(occupancy), 512'd55);
        check("t2_almfull_at55", 512'(in_almfull), 512'd0);
      end
    end
    check("t2_occ56", 512'(occupancy), 512'd56);
    check("t2_almfull_at56", 512'(in_almfull), 512'd1);
    check("t2_no_out_valid", 512'(out_cnt - base), 512'd0);

    // 8 more fill the FIFO without overflow.
    for (int i = 0; i < 8; i++) push(1'b1);
    check("t3_occ64", 512'(occupancy), 512'd64);
    check("t3_overflow", 512'(overflow), 512'd0);
    check("t3_almfull", 512'(in_almfull), 512'd1);

    // Push into full is dropped; overflow sticks.
    push(1'b0);
    check("t4_occ64", 512'(occupancy), 512'd64);
    check("t4_overflow", 512'(overflow), 512'd1);
    step();
    check("t4_overflow_sticky", 512'(overflow), 512'd1);
    check("t4_no_out_valid", 512'(out_cnt - base), 512'd0);

    // Drain 9 to reach 55, then simultaneous push+pop keeps 55 and almfull low.
    out_almfull = 1'b0;
    repeat (9) step();
    out_almfull = 1'b1;
    check("t5_occ55", 512'(occupancy), 512'd55);
    check("t5_almfull_drop", 512'(in_almfull), 512'd0);
    out_almfull = 1'b0;
    push(1'b1);
    out_almfull = 1'b1;
    check("t5_pushpop_occ", 512'(occupancy), 512'd55);
    check("t5_pushpop_almfull", 512'(in_almfull), 512'd0);
    step();
    check("t5_stalled_occ", 512'(occupancy), 512'd55);
    out_almfull = 1'b0;
    repeat (60) step();
    check("t5_drained_occ", 512'(occupancy), 512'd0);
    check("t5_queue_empty", 512'(exp_q.size()), 512'd0);
    check("t5_overflow_sticky", 512'(overflow), 512'd1);

    // Occupancy 30, reset mid-stream flushes everything.
    out_almfull = 1'b1;
    for (int i = 0; i < 30; i++) push(1'b1);
    check("t6_occ30", 512'(occupancy), 512'd30);
    out_almfull   = 1'b0;
    afu_softreset = 1'b1;
    #1;
    check_reset_vals("t6_async");
    exp_q.delete();
    base = out_cnt;
    repeat (3) step();
    check_reset_vals("t6_held");
    afu_softreset = 1'b0;
    repeat (4) step();
    check("t6_no_replay", 512'(out_cnt - base), 512'd0);
    check("t6_occ_after", 512'(occupancy), 512'd0);
    push(1'b1);
    check("t6_push_edge_no_out", 512'(out_valid), 512'd0);
    check("t6_push_occ", 512'(occupancy), 512'd1);
    step();
    check("t6_out_after_2", 512'(out_valid), 512'd1);
    check("t6_out_hdr", 512'(out_hdr), 512'(mk_hdr(tag_n - 1)));
    step();
    check("t6_single_pulse", 512'(out_valid), 512'd0);

`ifdef CCIP_C1_TX_BUFFER_STATS_EN
    afu_softreset = 1'b1;
    exp_q.delete();
    step();
    afu_softreset = 1'b0;
    step();
    for (int i = 0; i < 100; i++) begin
      out_almfull = (i >= 50 && i < 60);
      push(1'b1);
    end
    out_almfull = 1'b0;
    repeat (20) step();
    check("st_in_cnt", 512'(stat_in_cnt), 512'd100);
    check("st_out_cnt", 512'(stat_out_cnt), 512'd100);
    check("st_stall_cyc", 512'(stat_stall_cyc), 512'd10);
    check("st_max_occ", 512'(stat_max_occ), 512'd11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
